// File: rtl/regfile_pkg.sv
// Shared constants and strobe classification type for the one-hot-written register file.
package regfile_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_t;

endpackage

// File: rtl/regfile_onehot_check.sv
// Classifies a decoder strobe as zero-, one- or multi-hot and encodes its index.
module onehot_check #(
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [NREGS-1:0]       sel_i,
  output regfile_pkg::sel_class_t cls_o,
  output logic [ADDR_W-1:0]      idx_o
);

  import regfile_pkg::*;

  logic seen;
  logic multi;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first,
  // so the loop can build up state in order and no latch is inferred.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_i[i]) begin
        if (seen) multi = 1'b1;
        seen  = 1'b1;
        idx_o = ADDR_W'(i);
      end
    end
    if (multi)     cls_o = SEL_MULTI;
    else if (seen) cls_o = SEL_ONE;
    else           cls_o = SEL_ZERO;
  end

endmodule

// File: rtl/regfile_onehot_wr.sv
// Register file written by a one-hot decoder strobe, with two registered,
// write-first read ports, a sticky multi-hot error flag and a commit counter.
module regfile_onehot_wr #(
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREGS-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              sel_err,
  input  logic              err_clr,
  output logic [7:0]        wr_count
);

  import regfile_pkg::*;

  if ((2 ** ADDR_W) != NREGS) begin : g_bad_params
    $error("regfile_onehot_wr: 2**ADDR_W must equal NREGS");
  end

  sel_class_t        sel_cls;
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_commit;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q;
  logic              sel_err_q, sel_err_d;
  logic [7:0]        wr_count_q, wr_count_d;

  onehot_check #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_onehot_check (
    .sel_i (wr_sel),
    .cls_o (sel_cls),
    .idx_o (wr_idx)
  );

  // A write to the hardwired zero register is silently dropped, not an error.
  assign wr_commit = (sel_cls == SEL_ONE) && !(ZERO_REG && (wr_idx == '0));

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && (addr == '0))          return '0;
    else if (wr_commit && (wr_idx == addr)) return wr_data;
    else                                    return regs_q[addr];
  endfunction

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_en) begin
      rd_data_a_d = read_port(rd_addr_a);
      rd_data_b_d = read_port(rd_addr_b);
    end
  end

  // Set has priority over clear so a multi-hot strobe is never lost.
  always_comb begin
    sel_err_d = sel_err_q;
    if (sel_cls == SEL_MULTI) sel_err_d = 1'b1;
    else if (err_clr)         sel_err_d = 1'b0;
  end

  assign wr_count_d = wr_count_q + 8'(wr_commit);

  // NOTE: the storage array is reset along with the control state because
  // reads after reset must return zero; this costs a reset net per flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_en;
      sel_err_q   <= sel_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign sel_err   = sel_err_q;
  assign wr_count  = wr_count_q;

endmodule
